// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide. start accepted only when idle; result and done come XLEN+2 cycles later.
// No backpressure on the result: done is a one-cycle pulse, and busy stalls the upstream while an operation is in flight.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_addr
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2:0]        cur_op;
    logic [4:0]        cur_rd;
    logic [XLEN-1:0]   a_mag, b_mag, rem;
    logic              neg_a, neg_b;
    logic [2*XLEN-1:0] acc;

    logic              sgn_in, launch;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, div_cand;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_val;

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign launch = (state == IDLE) && start && !abort;

    // MULH, DIV and REM operate on magnitudes; the signs are re-applied in FIX.
    always_comb begin
        sgn_in = op[2] ? !op[0] : (op[1:0] == 2'b10);
        abs_a  = (sgn_in && operand_a[XLEN-1]) ? -operand_a : operand_a;
        abs_b  = (sgn_in && operand_b[XLEN-1]) ? -operand_b : operand_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && !abort) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = abort ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product, unconsumed multiplier} for multiply, or the
    // dividend shifting out of acc[XLEN-1] while quotient bits shift in at the bottom.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_cand = {rem, acc[XLEN-1]};
        div_ge   = div_cand >= {1'b0, b_mag};
        div_diff = div_cand[XLEN-1:0] - b_mag;
    end

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg_a ? -rem : rem;
        if (b_mag == '0) quo = '1;
        unique case (cur_op)
            3'b001, 3'b010: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: fix_val = quo;
            3'b110, 3'b111: fix_val = rmd;
            default:        fix_val = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            cur_op      <= '0;
            cur_rd      <= '0;
            a_mag       <= '0;
            b_mag       <= '0;
            rem         <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            acc         <= '0;
            result      <= '0;
            result_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        cur_op <= op;
                        cur_rd <= rd_addr;
                        a_mag  <= abs_a;
                        b_mag  <= abs_b;
                        neg_a  <= sgn_in && operand_a[XLEN-1];
                        neg_b  <= sgn_in && operand_b[XLEN-1];
                        rem    <= '0;
                        cnt    <= '0;
                        acc    <= {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
                    end
                end
                RUN: begin
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                    if (cur_op[2]) begin
                        rem            <= div_ge ? div_diff : div_cand[XLEN-1:0];
                        acc[XLEN-1:0]  <= {acc[XLEN-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (!abort) begin
                        result      <= fix_val;
                        result_addr <= cur_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized check of muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  result_addr;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd  = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rd_addr(rd_addr),
        .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
        .busy(busy), .done(done), .result(result), .result_addr(result_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'b001: begin p = ua * ub; return p[63:32]; end
            3'b010: begin p = 64'(sa * sb); return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : 32'(sa % sb);
            3'b111: return (b == 0) ? a : a % b;
            default: begin p = ua * ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called in cycle 0 of an idle unit; leaves the unit idle in cycle XLEN+3.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int bad;
        start = 1'b1; op = o; operand_a = a; operand_b = b; rd_addr = rd;
        tick();
        start = 1'b0; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom; rd_addr = 5'($urandom);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad++;
            tick();
        end
        check({tag, " busy_window"}, 64'(bad), 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " result"}, {32'd0, result}, {32'd0, exp});
        check({tag, " result_addr"}, {59'd0, result_addr}, {59'd0, rd});
        tick();
        check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
        last_exp = exp;
        last_rd  = rd;
    endtask

    initial begin : main
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          bad;

        tick();
        tick();
        check("reset_state", {25'd0, busy, done, result, result_addr}, 64'd0);
        reset = 1'b0;
        tick();

        run_op("mul_neg",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mulh_min",   3'b010, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_op("mulhu_ones", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run_op("mul_ones",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001);
        run_op("mul_op3",    3'b011, 32'd6,        32'd9,         5'd4,  32'd54);
        run_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFD);
        run_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFF);
        run_op("divu",       3'b101, 32'd100,      32'd7,         5'd8,  32'd14);
        run_op("remu",       3'b111, 32'd100,      32'd7,         5'd9,  32'd2);
        run_op("divu_zero",  3'b101, 32'd5,        32'd0,         5'd10, 32'hFFFF_FFFF);
        run_op("rem_zero",   3'b110, 32'd5,        32'd0,         5'd11, 32'd5);
        run_op("div_zero_n", 3'b100, 32'hFFFF_FFF0, 32'd0,        5'd12, 32'hFFFF_FFFF);
        run_op("rem_zero_n", 3'b110, 32'hFFFF_FFF0, 32'd0,        5'd13, 32'hFFFF_FFF0);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
        run_op("rd_zero",    3'b101, 32'd81,       32'd9,         5'd0,  32'd9);

        // A second start while running is ignored.
        start = 1'b1; op = 3'b101; operand_a = 32'd1000; operand_b = 32'd10; rd_addr = 5'd20;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'b000; operand_a = 32'd3; operand_b = 32'd3; rd_addr = 5'd21;
        tick();
        start = 1'b0;
        repeat (28) tick();
        check("restart_ignored done", {63'd0, done}, 64'd1);
        check("restart_ignored result", {32'd0, result}, 64'd100);
        check("restart_ignored addr", {59'd0, result_addr}, 64'd20);
        tick();
        tick();
        check("restart_ignored idle", {62'd0, busy, done}, 64'd0);
        last_exp = 32'd100;
        last_rd  = 5'd20;

        // abort together with start in IDLE wins.
        start = 1'b1; abort = 1'b1; op = 3'b000; operand_a = 32'd2; operand_b = 32'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start busy", {63'd0, busy}, 64'd0);
        tick();

        // abort in cycle 10 of a divide, then a fresh start in cycle 11.
        start = 1'b1; op = 3'b100; operand_a = 32'd1000; operand_b = 32'd3; rd_addr = 5'd22;
        tick();
        start = 1'b0;
        bad = 0;
        for (int c = 1; c < 10; c++) begin
            if (done !== 1'b0) bad++;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_mid no_done", 64'(bad), 64'd0);
        check("abort_mid idle", {62'd0, busy, done}, 64'd0);
        check("abort_mid result", {27'd0, result, result_addr}, {27'd0, last_exp, last_rd});
        run_op("after_abort", 3'b111, 32'd1000, 32'd3, 5'd23, 32'd1);

        // abort during DONE does not suppress the pulse.
        start = 1'b1; op = 3'b000; operand_a = 32'd3; operand_b = 32'd4; rd_addr = 5'd24;
        tick();
        start = 1'b0;
        repeat (33) tick();
        abort = 1'b1;
        check("abort_done pulse", {63'd0, done}, 64'd1);
        check("abort_done result", {32'd0, result}, 64'd12);
        tick();
        abort = 1'b0;
        check("abort_done idle", {62'd0, busy, done}, 64'd0);
        last_exp = 32'd12;
        last_rd  = 5'd24;

        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d op%0d", i, o), o, a, b, rd, ref_model(o, a, b));
        end

        // Reset in cycle 20 of an operation clears everything at once.
        start = 1'b1; op = 3'b001; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678; rd_addr = 5'd30;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        #1;
        check("midop_reset outputs", {25'd0, busy, done, result, result_addr}, 64'd0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        check("midop_reset quiet", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
